// File: rtl/hiscore_ram_if.sv
// Hiscore-side RAM access bus: pause handshake plus address/data lines.
// The hiscore initiator uses the master view, the game-side responder the slave view.
interface hiscore_ram_if;
  logic        pause_request;
  logic        paused;
  logic [15:0] hs_address;
  logic [7:0]  hs_data_in;
  logic        hs_write;
  logic [7:0]  hs_data_out;

  modport master (
    output pause_request, hs_address, hs_data_in, hs_write,
    input  paused, hs_data_out
  );

  modport slave (
    input  pause_request, hs_address, hs_data_in, hs_write,
    output paused, hs_data_out
  );
endinterface

// File: rtl/hiscore_ram_responder.sv
// Game-side responder: stalls the CPU at a safe point, hands work RAM to the hiscore
// initiator, maps hiscore addresses into the RAM window and returns read data.
module hiscore_ram_responder #(
  parameter int unsigned AW            = 11,
  parameter logic [15:0] HS_BASE       = 16'h8800,
  parameter int unsigned DRAIN_TIMEOUT = 255,
  parameter int unsigned RELEASE_DELAY = 2
) (
  input  logic          clk,
  input  logic          reset,
  hiscore_ram_if.slave  hs,
  output logic          cpu_pause,
  input  logic          cpu_bus_idle,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  input  logic          cpu_we,
  output logic [7:0]    cpu_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output logic          timeout_flag
);

  localparam logic [7:0] TmoLast = 8'(DRAIN_TIMEOUT - 1);
  localparam logic [3:0] RelLast = 4'(RELEASE_DELAY - 1);

  typedef enum logic [1:0] {StRun, StDrain, StGrant, StRelease} state_e;

  state_e      state_q;
  logic        paused_q;
  logic        cpu_pause_q;
  logic        timeout_flag_q;
  logic [1:0]  idle_cnt_q;
  logic [7:0]  tmo_cnt_q;
  logic [3:0]  rel_cnt_q;
  logic        win_q;

  logic [15:0] offset;
  logic        in_window;

  assign offset    = hs.hs_address - HS_BASE;
  assign in_window = (offset >> AW) == 16'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StRun;
      paused_q       <= 1'b0;
      cpu_pause_q    <= 1'b0;
      timeout_flag_q <= 1'b0;
      idle_cnt_q     <= 2'd0;
      tmo_cnt_q      <= 8'd0;
      rel_cnt_q      <= 4'd0;
      win_q          <= 1'b0;
    end else begin
      win_q <= 1'b0;
      unique case (state_q)
        StRun: begin
          idle_cnt_q <= 2'd0;
          tmo_cnt_q  <= 8'd0;
          rel_cnt_q  <= 4'd0;
          if (hs.pause_request) begin
            state_q     <= StDrain;
            cpu_pause_q <= 1'b1;
          end
        end
        StDrain: begin
          tmo_cnt_q  <= tmo_cnt_q + 8'd1;
          idle_cnt_q <= cpu_bus_idle ? idle_cnt_q + 2'd1 : 2'd0;
          // A withdrawn request wins over a grant due in the same cycle
          if (!hs.pause_request) begin
            state_q <= StRelease;
          end else if (cpu_bus_idle && idle_cnt_q == 2'd1) begin
            state_q  <= StGrant;
            paused_q <= 1'b1;
          end else if (tmo_cnt_q == TmoLast) begin
            state_q        <= StGrant;
            paused_q       <= 1'b1;
            timeout_flag_q <= 1'b1;
          end
        end
        StGrant: begin
          if (!hs.pause_request) begin
            state_q  <= StRelease;
            paused_q <= 1'b0;
          end else begin
            // Flag qualifies the RAM data that returns next cycle
            win_q <= in_window;
          end
        end
        StRelease: begin
          rel_cnt_q <= rel_cnt_q + 4'd1;
          if (rel_cnt_q == RelLast) begin
            state_q     <= StRun;
            cpu_pause_q <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    ram_addr  = cpu_addr;
    ram_we    = cpu_we;
    ram_wdata = cpu_wdata;
    if (state_q == StGrant) begin
      ram_addr  = offset[AW-1:0];
      ram_we    = hs.hs_write & in_window;
      ram_wdata = hs.hs_data_in;
    end
  end

  assign hs.paused      = paused_q;
  assign hs.hs_data_out = win_q ? ram_rdata : 8'h00;
  assign cpu_pause      = cpu_pause_q;
  assign timeout_flag   = timeout_flag_q;
  assign cpu_rdata      = ram_rdata;

endmodule

// File: tb/tb_hiscore_ram_responder.sv
// Randomised scoreboard bench for hiscore_ram_responder with a synchronous RAM model
// and a phase-level reference model of the pause/grant protocol.
module tb_hiscore_ram_responder;

  localparam int unsigned AW      = 11;
  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned RELDLY  = 2;
  localparam logic [15:0] BASE    = 16'h8800;

  localparam int PhRun = 0, PhDrain = 1, PhGrant = 2, PhRelease = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_pause, cpu_bus_idle, cpu_we, ram_we, timeout_flag;
  logic [AW-1:0] cpu_addr, ram_addr;
  logic [7:0]    cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;

  hiscore_ram_if hs_bus ();

  hiscore_ram_responder #(
    .AW            (AW),
    .HS_BASE       (BASE),
    .DRAIN_TIMEOUT (TIMEOUT),
    .RELEASE_DELAY (RELDLY)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hs           (hs_bus),
    .cpu_pause    (cpu_pause),
    .cpu_bus_idle (cpu_bus_idle),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_we       (cpu_we),
    .cpu_rdata    (cpu_rdata),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  // Work RAM: read returns the pre-write contents
  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  typedef struct {
    int          cyc;
    logic        paused, cpu_pause, tflag, we;
    logic [7:0]  hdo, crd, wd;
    logic [10:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model state
  logic [7:0]  ref_mem [0:2047];
  int          ph, drain_cyc, idle_run, rel_cyc;
  logic        m_paused, m_cpu_pause, m_tflag, m_win;
  logic [7:0]  m_rd;
  logic [10:0] x_addr;
  logic        x_we;
  logic [7:0]  x_wd;

  // Stimulus for the next cycle
  logic        d_reset, d_pr, d_idle, d_cwe, d_hwr;
  logic [10:0] d_caddr;
  logic [7:0]  d_cwd, d_hdin;
  logic [15:0] d_haddr;

  task automatic chk(input string name, input int c, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  function automatic logic hs_in_window(input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE;
    return off < 16'd2048;
  endfunction

  // Advance the model across one clock edge using the inputs of the cycle just ended
  task automatic model_edge();
    m_rd = ref_mem[x_addr];
    if (x_we) ref_mem[x_addr] = x_wd;
    if (reset) begin
      ph = PhRun; m_tflag = 1'b0; m_win = 1'b0;
      drain_cyc = 0; idle_run = 0; rel_cyc = 0;
    end else begin
      m_win = (ph == PhGrant) && hs_bus.pause_request && hs_in_window(hs_bus.hs_address);
      case (ph)
        PhRun: if (hs_bus.pause_request) begin
          ph = PhDrain; drain_cyc = 0; idle_run = 0;
        end
        PhDrain: begin
          drain_cyc++;
          idle_run = cpu_bus_idle ? idle_run + 1 : 0;
          if (!hs_bus.pause_request) begin
            ph = PhRelease; rel_cyc = 0;
          end else if (idle_run >= 2) begin
            ph = PhGrant;
          end else if (drain_cyc >= int'(TIMEOUT)) begin
            ph = PhGrant; m_tflag = 1'b1;
          end
        end
        PhGrant: if (!hs_bus.pause_request) begin
          ph = PhRelease; rel_cyc = 0;
        end
        default: begin
          rel_cyc++;
          if (rel_cyc >= int'(RELDLY)) ph = PhRun;
        end
      endcase
    end
    m_paused    = (ph == PhGrant);
    m_cpu_pause = (ph != PhRun);
  endtask

  task automatic tick();
    exp_t        e;
    logic [15:0] off;
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    reset                = d_reset;
    hs_bus.pause_request = d_pr;
    hs_bus.hs_address    = d_haddr;
    hs_bus.hs_data_in    = d_hdin;
    hs_bus.hs_write      = d_hwr;
    cpu_bus_idle         = d_idle;
    cpu_addr             = d_caddr;
    cpu_wdata            = d_cwd;
    cpu_we               = d_cwe;
    if (ph == PhGrant) begin
      off    = d_haddr - BASE;
      x_addr = off[10:0];
      x_we   = d_hwr && hs_in_window(d_haddr);
      x_wd   = d_hdin;
    end else begin
      x_addr = d_caddr;
      x_we   = d_cwe;
      x_wd   = d_cwd;
    end
    e.cyc = cyc; e.paused = m_paused; e.cpu_pause = m_cpu_pause; e.tflag = m_tflag;
    e.hdo = m_win ? m_rd : 8'h00; e.crd = m_rd;
    e.addr = x_addr; e.we = x_we; e.wd = x_wd;
    sb.push_back(e);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 4))
      0, 1:    return BASE + 16'($urandom_range(0, 2047));
      2:       return BASE + 16'($urandom_range(2040, 2055));
      3:       return BASE - 16'($urandom_range(1, 8));
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: compares whatever the DUT presents against the oldest expectation
  initial begin
    exp_t r;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        r = sb.pop_front();
        chk("paused", r.cyc, int'(hs_bus.paused), int'(r.paused));
        chk("cpu_pause", r.cyc, int'(cpu_pause), int'(r.cpu_pause));
        chk("timeout_flag", r.cyc, int'(timeout_flag), int'(r.tflag));
        chk("hs_data_out", r.cyc, int'(hs_bus.hs_data_out), int'(r.hdo));
        chk("cpu_rdata", r.cyc, int'(cpu_rdata), int'(r.crd));
        chk("ram_we", r.cyc, int'(ram_we), int'(r.we));
        chk("ram_addr", r.cyc, int'(ram_addr), int'(r.addr));
        chk("ram_wdata", r.cyc, int'(ram_wdata), int'(r.wd));
      end
    end
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    ram_rdata = 8'h00;
    ph = PhRun; drain_cyc = 0; idle_run = 0; rel_cyc = 0;
    m_tflag = 1'b0; m_win = 1'b0; m_rd = 8'h00;
    x_addr = '0; x_we = 1'b0; x_wd = 8'h00;
    reset = 1'b1; hs_bus.pause_request = 1'b0; hs_bus.hs_address = 16'h0;
    hs_bus.hs_data_in = 8'h00; hs_bus.hs_write = 1'b0;
    cpu_bus_idle = 1'b1; cpu_addr = '0; cpu_wdata = 8'h00; cpu_we = 1'b0;
    d_reset = 1'b1; d_pr = 1'b0; d_idle = 1'b1; d_cwe = 1'b0; d_hwr = 1'b0;
    d_caddr = '0; d_cwd = 8'h00; d_hdin = 8'h00; d_haddr = 16'h0;

    ticks(3);
    d_reset = 1'b0;
    ticks(2);

    // Clean drain with an idle bus
    d_pr = 1'b1;
    ticks(4);
    // In-window write then read-back
    d_haddr = 16'h8805; d_hdin = 8'hA5; d_hwr = 1'b1;
    tick();
    d_hwr = 1'b0;
    ticks(3);
    // Window edges on both sides
    d_haddr = 16'h9000; d_hdin = 8'h5A; d_hwr = 1'b1;
    tick();
    d_haddr = 16'h87FF;
    tick();
    d_hwr = 1'b0;
    ticks(2);
    // Release, then a CPU write in RUN
    d_pr = 1'b0;
    ticks(4);
    d_caddr = 11'h010; d_cwd = 8'h3C; d_cwe = 1'b1;
    tick();
    d_cwe = 1'b0;
    ticks(2);
    d_pr = 1'b1;
    ticks(4);
    d_haddr = 16'h8810;
    ticks(3);
    d_pr = 1'b0;
    ticks(5);
    // Forced grant on a busy CPU bus
    d_idle = 1'b0; d_pr = 1'b1;
    ticks(260);
    d_pr = 1'b0;
    ticks(6);
    // Reset in the middle of a grant
    d_idle = 1'b1; d_pr = 1'b1;
    ticks(5);
    d_reset = 1'b1;
    tick();
    d_reset = 1'b0; d_pr = 1'b0;
    ticks(4);
    // Request re-asserted during release
    d_pr = 1'b1;
    ticks(4);
    d_pr = 1'b0;
    tick();
    d_pr = 1'b1;
    ticks(6);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 29) == 0) d_pr = ~d_pr;
      d_idle  = ($urandom_range(0, 3) != 0);
      d_haddr = pick_addr();
      d_hdin  = 8'($urandom);
      d_hwr   = $urandom_range(0, 1) == 1;
      d_caddr = 11'($urandom);
      d_cwd   = 8'($urandom);
      d_cwe   = $urandom_range(0, 3) == 0;
      d_reset = $urandom_range(0, 299) == 0;
      tick();
    end
    d_reset = 1'b0; d_pr = 1'b0; d_hwr = 1'b0; d_cwe = 1'b0;
    ticks(5);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hiscore_ram_responder.md
Name: hiscore_ram_responder

Overview:
- Game-side responder for the hiscore RAM-access protocol: it services `pause_request`, `ram_address`, `ram_write` and the data buses issued by the hiscore initiator.
- It stalls the game CPU at a safe bus boundary, then grants the hiscore exclusive access to the game work RAM.
- It translates hiscore addresses into the RAM's local address space and returns read data with fixed latency.
- It sits between the game core's CPU/work-RAM path and the hiscore module, on `clk_sys`.

Parameters:
- AW, 11: work-RAM address width; window size is 2^AW bytes.
- HS_BASE, 16'h8800: CPU-space address that maps to RAM address 0.
- DRAIN_TIMEOUT, 255: max cycles spent waiting for CPU bus idle before forcing the grant (8-bit counter).
- RELEASE_DELAY, 2: cycles `cpu_pause` is held after the grant ends (range 1..15).

Ports:
- clk  in  1  system clock (`clk_sys`)
- reset  in  1  synchronous, active-high
- pause_request  in  1  hiscore requests RAM ownership
- paused  out  1  grant indication to hiscore
- cpu_pause  out  1  hold/wait to CPU core
- cpu_bus_idle  in  1  CPU not in a memory cycle
- cpu_addr  in  AW  CPU RAM address
- cpu_wdata  in  8  CPU write data
- cpu_we  in  1  CPU write strobe
- cpu_rdata  out  8  RAM read data to CPU
- hs_address  in  16  hiscore CPU-space address
- hs_data_in  in  8  hiscore write data (to RAM)
- hs_write  in  1  hiscore write strobe
- hs_data_out  out  8  read data to hiscore
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, 1-cycle synchronous latency
- timeout_flag  out  1  sticky: a grant was forced by timeout

Behaviour:
- The interface is decided: one clock, `clk`. `reset` is synchronous and active-high.
- Reset, whenever asserted (including mid-GRANT): state=RUN; `paused`, `cpu_pause`, `timeout_flag` = 0; all counters = 0; in-window flag = 0; `hs_data_out` = 8'h00.
- FSM: RUN, DRAIN, GRANT, RELEASE. All outputs are registered except the RAM mux and `cpu_rdata`.
- RUN:
  - CPU owns the RAM: `ram_addr`=`cpu_addr`, `ram_we`=`cpu_we`, `ram_wdata`=`cpu_wdata`.
  - `pause_request`=1 -> DRAIN; `cpu_pause` rises on the same edge.
- DRAIN:
  - `cpu_pause`=1. The RAM stays muxed to the CPU so an in-flight cycle completes.
  - Idle counter: increments while `cpu_bus_idle`=1, clears when it is 0.
  - Idle counter reaches 2 -> GRANT.
  - Else the timeout counter reaches DRAIN_TIMEOUT -> GRANT and `timeout_flag` is set.
  - `pause_request`=0 -> RELEASE; this takes precedence over the grant condition in the same cycle.
- GRANT:
  - `paused`=1, asserted on the entry edge.
  - RAM is muxed to the hiscore. Offset = `hs_address` − HS_BASE (16-bit wraparound subtraction). In-window when offset < 2^AW; `ram_addr` = offset[AW-1:0].
  - Writes: `ram_we` = `hs_write` & in-window. Out-of-window writes are dropped and `ram_we` stays 0.
  - Reads: the in-window flag is registered each cycle. `hs_data_out` = `ram_rdata` if that flag was set, else 8'h00, giving 1-cycle read latency.
  - CPU writes are ignored in GRANT.
  - `pause_request`=0 -> RELEASE; `paused` falls on the same edge.
- RELEASE:
  - `paused`=0, `cpu_pause`=1, RAM muxed back to the CPU.
  - Counts RELEASE_DELAY cycles, then -> RUN and `cpu_pause`=0.
  - `pause_request` re-asserted during RELEASE is not honoured until RUN; it then goes to DRAIN the next cycle.
- `hs_data_out` is held at 8'h00 outside GRANT.
- `hs_write` outside GRANT never reaches the RAM.
- `cpu_rdata` = `ram_rdata`, passed through in all states.
- `timeout_flag` clears only on reset.

Test Plan:
- Reset, then `pause_request`=1 with `cpu_bus_idle`=1 constant -> `cpu_pause`=1 at +1 cycle, `paused`=1 at +3 cycles, `timeout_flag`=0.
- In GRANT, write `hs_address`=16'h8805 with `hs_data_in`=8'hA5 -> `ram_addr`=11'h005 and `ram_we`=1. A read of 16'h8805 next gives `hs_data_out`=8'hA5 one cycle later.
- In GRANT, access `hs_address`=16'h9000 (offset 0x800) and 16'h87FF -> `ram_we`=0, `hs_data_out`=8'h00 for both.
- `pause_request`=1 with `cpu_bus_idle`=0 held -> GRANT after 255 cycles, `timeout_flag`=1 and it stays 1 after a full release.
- Drop `pause_request` in GRANT -> `paused`=0 on the next edge; `cpu_pause` stays 1 for 2 cycles, then 0. A CPU write of 8'h3C to address 0x010 in RUN lands in RAM.
- Assert reset mid-GRANT -> `paused`, `cpu_pause`, `hs_data_out` are 0 on the next edge and the RAM mux is back to the CPU.
